// File: rtl/tracking_pkg.sv
// Shared definitions for the tracking-channel register readback path.
//   - State-word addresses within one tracking channel's register window.
//   - Burst readback FSM state encoding.
package tracking_pkg;

    // State-word addresses inside a channel
    localparam int PRN_STATE  = 6;
    localparam int PRN_COUNT  = 7;
    localparam int CARR_PHASE = 8;
    localparam int CARR_COUNT = 9;
    localparam int CODE_PHASE = 10;
    localparam int CNT_WORD   = 11;
    localparam int FLAG_WORD  = 12;
    localparam int DECODE     = 13;
    localparam int PRN2_STATE = 15;
    localparam int ACC_BASE   = 16;

    // Burst readback FSM
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FREEZE = 2'd1,
        ISSUE  = 2'd2,
        DRAIN  = 2'd3
    } state_t;

endpackage

// File: rtl/state_rd_fifo.sv
// Output FIFO for the channel state reader.
// Holds {last, data} entries; the head entry is presented from registers.
// Ports:
//   clk, rst_b      clock, asynchronous active-low reset
//   flush           drop all entries (wins over push)
//   push, push_data write one entry
//   pop             consume the head entry (ignored when empty)
//   out_valid       FIFO not empty
//   out_data        head entry, 0 when empty
//   count           current occupancy, feeds the reader's credit check
module state_rd_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (cnt != CNT_W'(DEPTH));
    assign do_pop  = pop && (cnt != '0);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; unwritten entries are never presented.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign out_valid = (cnt != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign count     = cnt;

endmodule

// File: rtl/channel_state_reader.sv
// Burst readback engine for tracking-channel state words.
// A host request (channel, first word, words-1) is latched, the channel is
// optionally frozen, then word addresses are issued to the channel bank under
// FIFO credit, the registered channel data is captured one clock later and
// streamed out through a small FIFO with a last-word tag.
//
// Build option: define BURST_FREEZE_EN to hold the selected channel
// (st_freeze) for the whole burst and wait FREEZE_CYC settle cycles before the
// first issue. Without it st_freeze stays 0 and issuing starts right away.
//
// Ports:
//   clk, rst_b                      clock, asynchronous active-low reset
//   req_valid/req_ready             burst request handshake (ready only in IDLE)
//   req_ch, req_addr, req_len       channel, first word, words-1
//   abort                           cancel burst, flush everything
//   rd_valid/rd_ready               output word handshake
//   rd_data, rd_last                output word and final-word tag
//   busy                            FSM active or output FIFO not empty
//   st_addr, st_ch_sel              issued word address / one-hot channel select
//   st_freeze                       one-hot channel hold request
//   ch_rdata                        per-channel registered state words
module channel_state_reader
    import tracking_pkg::*;
#(
    parameter int CH_NUM     = 8,
    parameter int CH_BITS    = 3,
    parameter int ADDR_BITS  = 5,
    parameter int LEN_BITS   = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int FREEZE_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [CH_BITS-1:0]     req_ch,
    input  logic [ADDR_BITS-1:0]   req_addr,
    input  logic [LEN_BITS-1:0]    req_len,
    input  logic                   abort,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [31:0]            rd_data,
    output logic                   rd_last,
    output logic                   busy,
    output logic [ADDR_BITS-1:0]   st_addr,
    output logic [CH_NUM-1:0]      st_ch_sel,
    output logic [CH_NUM-1:0]      st_freeze,
    input  logic [CH_NUM*32-1:0]   ch_rdata
);

`ifdef BURST_FREEZE_EN
    localparam bit FREEZE_EN = 1'b1;
`else
    localparam bit FREEZE_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int REM_W = LEN_BITS + 1;
    localparam int FRZ_W = (FREEZE_CYC > 1) ? $clog2(FREEZE_CYC) : 1;

    // Out-of-range channel indices decode to an all-zero select.
    function automatic logic [CH_NUM-1:0] ch_onehot(input logic [CH_BITS-1:0] ch);
        logic [CH_NUM-1:0] oh;
        oh = '0;
        for (int i = 0; i < CH_NUM; i++) oh[i] = (ch == CH_BITS'(i));
        return oh;
    endfunction

    // An empty select yields 32'h0, which is what an invalid channel returns.
    function automatic logic [31:0] sel_word(input logic [CH_NUM-1:0]    sel,
                                             input logic [CH_NUM*32-1:0] bus);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (sel[i]) w = w | bus[i*32 +: 32];
        end
        return w;
    endfunction

    state_t             state;
    logic [CH_BITS-1:0] ch_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [REM_W-1:0]   rem_q;
    logic [FRZ_W-1:0]   frz_cnt;
    logic               freeze_on;

    logic               vld_p0;
    logic               last_p0;
    logic [CH_NUM-1:0]  sel_p0;

    logic [CNT_W-1:0]   fifo_count;
    logic               credit_ok;
    logic               issue;
    logic               issue_last;
    logic [32:0]        fifo_out;

    // Words issued but not yet in the FIFO occupy credit too.
    assign credit_ok  = (int'(fifo_count) + int'(vld_p0)) < FIFO_DEPTH;
    assign issue      = (state == ISSUE) && credit_ok && !abort;
    assign issue_last = issue && (rem_q == REM_W'(1));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            rem_q     <= '0;
            frz_cnt   <= '0;
            freeze_on <= 1'b0;
            vld_p0    <= 1'b0;
        end else begin
            vld_p0 <= issue;
            if (abort) begin
                state     <= IDLE;
                freeze_on <= 1'b0;
                vld_p0    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_valid) begin
                            rem_q     <= {1'b0, req_len} + REM_W'(1);
                            frz_cnt   <= '0;
                            freeze_on <= FREEZE_EN;
                            state     <= FREEZE_EN ? FREEZE : ISSUE;
                        end
                    end
                    FREEZE: begin
                        if (int'(frz_cnt) >= FREEZE_CYC - 1) state <= ISSUE;
                        else frz_cnt <= frz_cnt + FRZ_W'(1);
                    end
                    ISSUE: begin
                        if (issue) begin
                            rem_q <= rem_q - REM_W'(1);
                            if (issue_last) state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (!vld_p0 && (fifo_count == '0)) begin
                            state     <= IDLE;
                            freeze_on <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Request fields and the issue pointer are datapath only; they are
    // always qualified by FSM state before reaching an output.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid && !abort) begin
            ch_q   <= req_ch;
            addr_q <= req_addr;
        end else if (issue) begin
            addr_q <= addr_q + ADDR_BITS'(1);
        end
    end

    // ---- issue stage -> p0: remember select and last tag of the issued word
    always_ff @(posedge clk) begin
        sel_p0  <= ch_onehot(ch_q);
        last_p0 <= issue_last;
    end

    // ---- p0 -> FIFO: channel data is valid one clock after issue
    state_rd_fifo #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .flush     (abort),
        .push      (vld_p0),
        .push_data ({last_p0, sel_word(sel_p0, ch_rdata)}),
        .pop       (rd_ready),
        .out_valid (rd_valid),
        .out_data  (fifo_out),
        .count     (fifo_count)
    );

    assign rd_data   = fifo_out[31:0];
    assign rd_last   = fifo_out[32];
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE) || (fifo_count != '0);
    assign st_addr   = issue ? addr_q : '0;
    assign st_ch_sel = issue ? ch_onehot(ch_q) : '0;
    assign st_freeze = (FREEZE_EN && freeze_on) ? ch_onehot(ch_q) : '0;

endmodule

// File: tb/tb_channel_state_reader.sv
module tb_channel_state_reader;
    import tracking_pkg::*;

    localparam int CH_NUM     = 8;
    localparam int CH_BITS    = 4;
    localparam int ADDR_BITS  = 5;
    localparam int LEN_BITS   = 5;
    localparam int FIFO_DEPTH = 4;
    localparam int FREEZE_CYC = 2;
`ifdef BURST_FREEZE_EN
    localparam bit FRZ     = 1'b1;
    localparam int EXP_LAT = FREEZE_CYC + 3;
`else
    localparam bit FRZ     = 1'b0;
    localparam int EXP_LAT = 3;
`endif

    logic                 clk;
    logic                 rst_b;
    logic                 req_valid;
    logic                 req_ready;
    logic [CH_BITS-1:0]   req_ch;
    logic [ADDR_BITS-1:0] req_addr;
    logic [LEN_BITS-1:0]  req_len;
    logic                 abort;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [31:0]          rd_data;
    logic                 rd_last;
    logic                 busy;
    logic [ADDR_BITS-1:0] st_addr;
    logic [CH_NUM-1:0]    st_ch_sel;
    logic [CH_NUM-1:0]    st_freeze;
    logic [CH_NUM*32-1:0] ch_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [32:0] exp_q[$];
    logic [CH_NUM-1:0] cur_oh;

    channel_state_reader #(
        .CH_NUM(CH_NUM), .CH_BITS(CH_BITS), .ADDR_BITS(ADDR_BITS),
        .LEN_BITS(LEN_BITS), .FIFO_DEPTH(FIFO_DEPTH), .FREEZE_CYC(FREEZE_CYC)
    ) dut (
        .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready),
        .req_ch(req_ch), .req_addr(req_addr), .req_len(req_len), .abort(abort),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .st_addr(st_addr), .st_ch_sel(st_ch_sel), .st_freeze(st_freeze),
        .ch_rdata(ch_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mkword(input int c, input int a);
        return 32'hA500_0000 | (32'(c) << 16) | 32'(a & 31);
    endfunction

    // Channel bank: each channel registers the word at st_addr every clock.
    always @(posedge clk) begin
        for (int c = 0; c < CH_NUM; c++) ch_rdata[c*32 +: 32] <= mkword(c, int'(st_addr));
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_req(input int ch, input int addr, input int len);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready_before_req got %b want 1", req_ready);
        end
        for (int i = 0; i <= len; i++)
            exp_q.push_back({1'(i == len), (ch < CH_NUM) ? mkword(ch, addr + i) : 32'h0});
        cur_oh    = (ch < CH_NUM) ? CH_NUM'(1 << ch) : '0;
        req_ch    = CH_BITS'(ch);
        req_addr  = ADDR_BITS'(addr);
        req_len   = LEN_BITS'(len);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // mode 0: rd_ready always 1; mode 1: rd_ready one cycle in four.
    task automatic run_burst(input int mode, output int first_lat);
        int k = 0;
        int outstanding = 0;
        int w = 0;
        bit prev_hold = 0;
        logic [32:0] prev_word = '0;
        logic [32:0] exp;
        first_lat = -1;
        while (exp_q.size() != 0 && k < 600) begin
            rd_ready = (mode == 0) ? 1'b1 : ((k % 4) == 3);
            if (first_lat < 0 && rd_valid === 1'b1) first_lat = k + 1;
            if (prev_hold) begin
                n_tests++;
                if (rd_valid !== 1'b1 || {rd_last, rd_data} !== prev_word) begin
                    n_fail++;
                    $display("FAIL hold_stable got v=%b %h want v=1 %h", rd_valid, {rd_last, rd_data}, prev_word);
                end
            end
            if (st_ch_sel !== '0) begin
                outstanding++;
                n_tests++;
                if (st_ch_sel !== cur_oh) begin
                    n_fail++;
                    $display("FAIL st_ch_sel got %b want %b", st_ch_sel, cur_oh);
                end
                n_tests++;
                if (outstanding > FIFO_DEPTH) begin
                    n_fail++;
                    $display("FAIL credit outstanding %0d limit %0d", outstanding, FIFO_DEPTH);
                end
            end
            n_tests++;
            if (st_freeze !== (FRZ ? cur_oh : '0)) begin
                n_fail++;
                $display("FAIL st_freeze_burst got %b want %b", st_freeze, FRZ ? cur_oh : '0);
            end
            prev_hold = (rd_valid === 1'b1) && !rd_ready;
            prev_word = {rd_last, rd_data};
            if (rd_valid === 1'b1 && rd_ready) begin
                exp = exp_q.pop_front();
                outstanding--;
                n_tests++;
                if ({rd_last, rd_data} !== exp) begin
                    n_fail++;
                    $display("FAIL word got last=%b data=%h want last=%b data=%h",
                             rd_last, rd_data, exp[32], exp[31:0]);
                end
            end
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL burst_timeout words left %0d want 0", exp_q.size());
            exp_q.delete();
        end
        rd_ready = 1'b1;
        while (req_ready !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        n_tests++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || st_freeze !== '0 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_burst_idle got ready=%b busy=%b frz=%b vld=%b want 1 0 0 0",
                     req_ready, busy, st_freeze, rd_valid);
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0; req_valid = 1'b0; req_ch = '0; req_addr = '0; req_len = '0;
        abort = 1'b0; rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        n_tests++;
        if (rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rd got v=%b l=%b d=%h want 0 0 0", rd_valid, rd_last, rd_data);
        end
        n_tests++;
        if (busy !== 1'b0 || st_addr !== '0 || st_ch_sel !== '0 || st_freeze !== '0) begin
            n_fail++;
            $display("FAIL reset_st got busy=%b addr=%h sel=%b frz=%b want 0", busy, st_addr, st_ch_sel, st_freeze);
        end
        rst_b = 1'b1;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset got ready=%b busy=%b want 1 0", req_ready, busy);
        end
    endtask

    task automatic test_single();
        int lat;
        rd_ready = 1'b1;
        send_req(2, PRN_STATE, 0);
        run_burst(0, lat);
        n_tests++;
        if (lat !== EXP_LAT) begin
            n_fail++;
            $display("FAIL single_latency got %0d want %0d", lat, EXP_LAT);
        end
    endtask

    task automatic test_wrap();
        int lat;
        send_req(5, 30, 3);
        run_burst(0, lat);
    endtask

    task automatic test_backpressure();
        int lat;
        send_req(3, ACC_BASE, 15);
        run_burst(1, lat);
    endtask

    task automatic test_bad_channel();
        int lat;
        send_req(9, CNT_WORD, 1);
        run_burst(0, lat);
    endtask

    task automatic test_abort();
        int issues = 0;
        int k = 0;
        int lat;
        rd_ready = 1'b0;
        send_req(1, 0, 7);
        while (issues < 3 && k < 20) begin
            if (st_ch_sel !== '0) issues++;
            if (issues < 3) begin
                @(negedge clk);
                k++;
            end
        end
        n_tests++;
        if (issues != 3) begin
            n_fail++;
            $display("FAIL abort_issue_count got %0d want 3", issues);
        end
        n_tests++;
        if (rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_fifo_filled got %b want 1", rd_valid);
        end
        abort = 1'b1;
        @(negedge clk);
        n_tests++;
        if (rd_valid !== 1'b0 || st_freeze !== '0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_clear got vld=%b frz=%b ready=%b busy=%b want 0 0 1 0",
                     rd_valid, st_freeze, req_ready, busy);
        end
        abort = 1'b0;
        exp_q.delete();
        @(negedge clk);
        n_tests++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_stale got %b want 0", rd_valid);
        end
        rd_ready = 1'b1;
        send_req(4, DECODE, 1);
        run_burst(0, lat);
    endtask

    task automatic test_reset_mid();
        int lat;
        rd_ready = 1'b0;
        send_req(6, 20, 7);
        repeat (3) @(negedge clk);
        n_tests++;
        if (st_ch_sel !== 8'b0100_0000) begin
            n_fail++;
            $display("FAIL mid_issue_before_reset got %b want 01000000", st_ch_sel);
        end
        rst_b = 1'b0;
        #1;
        n_tests++;
        if (req_ready !== 1'b1 || rd_valid !== 1'b0 || busy !== 1'b0 || rd_data !== 32'h0 || rd_last !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_rd got ready=%b vld=%b busy=%b d=%h l=%b want 1 0 0 0 0",
                     req_ready, rd_valid, busy, rd_data, rd_last);
        end
        n_tests++;
        if (st_ch_sel !== '0 || st_freeze !== '0 || st_addr !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_st got sel=%b frz=%b addr=%h want 0", st_ch_sel, st_freeze, st_addr);
        end
        exp_q.delete();
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rd_ready = 1'b1;
        send_req(0, 31, 1);
        run_burst(0, lat);
        n_tests++;
        if (lat !== EXP_LAT) begin
            n_fail++;
            $display("FAIL recover_latency got %0d want %0d", lat, EXP_LAT);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_bad_channel();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
